// File: rtl/timer_counter_if.sv
// Control/status bundle between the APB register block and the timer counting core.
// The register block drives TDR/TCR/clear strobes; the core returns TCNT and the sticky flags.
interface timer_counter_if;
    localparam int unsigned DATA_WIDTH = 8;

    logic [DATA_WIDTH-1:0] TDR;
    logic [7:0]            TCR;
    logic                  OVF_CLR;
    logic                  UDF_CLR;
    logic [DATA_WIDTH-1:0] TCNT;
    logic                  TMR_OVF;
    logic                  TMR_UDF;

    modport master (
        output TDR, TCR, OVF_CLR, UDF_CLR,
        input  TCNT, TMR_OVF, TMR_UDF
    );

    modport slave (
        input  TDR, TCR, OVF_CLR, UDF_CLR,
        output TCNT, TMR_OVF, TMR_UDF
    );
endinterface

// File: rtl/timer_counter.sv
// 8-bit timer counting core: clock-select prescaler, parallel load, up/down counter
// and sticky overflow/underflow flags with W1C-style clear strobes.
module timer_counter (
    input  logic            PCLK,
    input  logic            PRESET,
    timer_counter_if.slave  bus
);
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned DIV_WIDTH  = 4;

    logic [DATA_WIDTH-1:0] r_tcnt;
    logic                  r_ovf;
    logic                  r_udf;
    logic [DIV_WIDTH-1:0]  r_div;

    logic                  w_load;
    logic                  w_down;
    logic                  w_en;
    logic [1:0]            w_cks;
    logic                  w_tick;
    logic [DIV_WIDTH-1:0]  w_div_nxt;
    logic [DATA_WIDTH-1:0] w_tcnt_nxt;
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic                  w_unused_tcr;

    assign w_load       = bus.TCR[7];
    assign w_down       = bus.TCR[5];
    assign w_en         = bus.TCR[4];
    assign w_cks        = bus.TCR[1:0];
    assign w_unused_tcr = ^{bus.TCR[6], bus.TCR[3:2]};

    // Tick when the low CKS+1 prescaler bits are all ones
    always_comb begin
        w_tick = 1'b0;
        case (w_cks)
            2'd0:    w_tick = r_div[0];
            2'd1:    w_tick = &r_div[1:0];
            2'd2:    w_tick = &r_div[2:0];
            default: w_tick = &r_div[3:0];
        endcase
    end

    // Prescaler restarts from zero whenever counting is paused or a load is in progress
    always_comb begin
        w_div_nxt = r_div + DIV_WIDTH'(1);
        if (!w_en || w_load) begin
            w_div_nxt = '0;
        end
    end

    always_comb begin
        w_tcnt_nxt = r_tcnt;
        w_ovf_set  = 1'b0;
        w_udf_set  = 1'b0;
        if (w_load) begin
            w_tcnt_nxt = bus.TDR;
        end else if (w_en && w_tick) begin
            if (!w_down) begin
                w_tcnt_nxt = r_tcnt + DATA_WIDTH'(1);
                w_ovf_set  = (r_tcnt == '1);
            end else begin
                w_tcnt_nxt = r_tcnt - DATA_WIDTH'(1);
                w_udf_set  = (r_tcnt == '0);
            end
        end
    end

    // Set has priority over a simultaneous clear strobe
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_tcnt <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
            r_div  <= '0;
        end else begin
            r_tcnt <= w_tcnt_nxt;
            r_ovf  <= w_ovf_set | (r_ovf & ~bus.OVF_CLR);
            r_udf  <= w_udf_set | (r_udf & ~bus.UDF_CLR);
            r_div  <= w_div_nxt;
        end
    end

    assign bus.TCNT    = r_tcnt;
    assign bus.TMR_OVF = r_ovf;
    assign bus.TMR_UDF = r_udf;
endmodule
